mem_arbiter: RTL and testbench

- Shares the single-port word memory (8-bit word address, 32-bit data, 4-bit byte mask, one-cycle registered read) between two requesters: instruction fetch (IF, read-only) and load/store (LS, read/write).
- Converts byte addresses to word indices and rejects misaligned or out-of-range accesses without touching memory.
- Arbitrates round-robin on conflict and returns responses with valid/ready backpressure through one per-port response slot.
- Sits between the core's fetch/LSU stages and the memory instance.

---
 rtl/rv_mem_pkg.sv | 27 ++
 rtl/mem_rsp_slot.sv | 66 ++++++
 rtl/mem_arbiter.sv | 106 ++++++++++
 tb/tb_mem_arbiter.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_mem_pkg.sv
// Shared types and helpers for the two-port memory arbiter.
// Holds the response-slot states, port indices, the LS request bundle and the address check.
package rv_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PEND = 2'd1,
        HOLD = 2'd2
    } slot_state_e;

    localparam int unsigned PORT_IF = 0;
    localparam int unsigned PORT_LS = 1;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  mask;
    } req_t;

    // Misaligned, bits above the word index set, or word past the populated depth.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned aw,
                                      input int unsigned depth);
        return (addr[1:0] != 2'b00) || ((addr >> (aw + 2)) != 32'd0) || ((addr >> 2) >= depth);
    endfunction

endpackage

// File: rtl/mem_rsp_slot.sv
// Per-port response slot: presents read data live for one cycle, then parks it
// in a hold register while the consumer stalls.
module mem_rsp_slot
    import rv_mem_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_accept,
    input  logic        i_err,
    input  logic        i_keep_data,
    input  logic [31:0] i_mem_data_out,
    input  logic        i_rsp_ready,
    output logic        o_eligible,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_err
);

    slot_state_e r_state;
    logic        r_err;
    logic        r_keep;
    logic [31:0] r_hold;
    logic [31:0] w_pend_data;

    assign w_pend_data = r_keep ? i_mem_data_out : 32'd0;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_err   <= 1'b0;
            r_keep  <= 1'b0;
            r_hold  <= 32'd0;
        end else if (i_accept) begin
            r_state <= PEND;
            r_err   <= i_err;
            r_keep  <= i_keep_data & ~i_err;
        end else begin
            case (r_state)
                PEND: begin
                    if (i_rsp_ready) begin
                        r_state <= IDLE;
                    end else begin
                        r_state <= HOLD;
                        r_hold  <= w_pend_data;
                    end
                end
                HOLD: begin
                    if (i_rsp_ready) r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_comb begin
        o_eligible  = (r_state == IDLE) || i_rsp_ready;
        o_rsp_valid = (r_state != IDLE);
        o_rsp_err   = (r_state != IDLE) && r_err;
        case (r_state)
            PEND:    o_rsp_data = w_pend_data;
            HOLD:    o_rsp_data = r_hold;
            default: o_rsp_data = 32'd0;
        endcase
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one single-port word memory between instruction fetch and load/store,
// with address checking, round-robin arbitration and per-port response slots.
module mem_arbiter
    import rv_mem_pkg::*;
#(
    parameter int unsigned MEM_AW    = 8,
    parameter int unsigned MEM_DEPTH = 255,
    parameter int unsigned LS_FIRST  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req_valid,
    output logic              if_req_ready,
    input  logic [31:0]       if_req_addr,
    output logic              if_rsp_valid,
    input  logic              if_rsp_ready,
    output logic [31:0]       if_rsp_data,
    output logic              if_rsp_err,
    input  logic              ls_req_valid,
    output logic              ls_req_ready,
    input  logic              ls_req_we,
    input  logic [31:0]       ls_req_addr,
    input  logic [31:0]       ls_req_wdata,
    input  logic [3:0]        ls_req_mask,
    output logic              ls_rsp_valid,
    input  logic              ls_rsp_ready,
    output logic [31:0]       ls_rsp_rdata,
    output logic              ls_rsp_err,
    output logic              mem_request,
    output logic              mem_we_re,
    output logic [MEM_AW-1:0] mem_address,
    output logic [31:0]       mem_data_in,
    output logic [3:0]        mem_mask,
    input  logic [31:0]       mem_data_out
);

    req_t w_ls_req;
    logic w_if_err;
    logic w_ls_err;
    logic w_if_slot_elig;
    logic w_ls_slot_elig;
    logic w_if_elig;
    logic w_ls_elig;
    logic w_grant_if;
    logic w_grant_ls;
    logic r_ls_prio;

    assign w_ls_req = '{we: ls_req_we, addr: ls_req_addr, wdata: ls_req_wdata,
                        mask: ls_req_mask};

    assign w_if_err  = addr_err(if_req_addr, MEM_AW, MEM_DEPTH);
    assign w_ls_err  = addr_err(w_ls_req.addr, MEM_AW, MEM_DEPTH);
    assign w_if_elig = if_req_valid & w_if_slot_elig;
    assign w_ls_elig = ls_req_valid & w_ls_slot_elig;

    // r_ls_prio set means LS wins the next conflict.
    assign w_grant_ls = w_ls_elig & (~w_if_elig | r_ls_prio);
    assign w_grant_if = w_if_elig & ~w_grant_ls;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ls_prio <= (LS_FIRST != 0);
        end else if (w_if_elig && w_ls_elig) begin
            r_ls_prio <= ~w_grant_ls;
        end
    end

    always_comb begin
        if_req_ready = w_grant_if;
        ls_req_ready = w_grant_ls;
        mem_request  = (w_grant_if & ~w_if_err) | (w_grant_ls & ~w_ls_err);
        mem_we_re    = w_grant_ls & w_ls_req.we;
        mem_address  = w_grant_ls ? ls_req_addr[MEM_AW+1:2] : if_req_addr[MEM_AW+1:2];
        mem_data_in  = w_ls_req.wdata;
        mem_mask     = (w_grant_ls && w_ls_req.we) ? w_ls_req.mask : 4'b0000;
    end

    mem_rsp_slot u_if_slot (
        .clk           (clk),
        .rst           (rst),
        .i_accept      (w_grant_if),
        .i_err         (w_if_err),
        .i_keep_data   (1'b1),
        .i_mem_data_out(mem_data_out),
        .i_rsp_ready   (if_rsp_ready),
        .o_eligible    (w_if_slot_elig),
        .o_rsp_valid   (if_rsp_valid),
        .o_rsp_data    (if_rsp_data),
        .o_rsp_err     (if_rsp_err)
    );

    mem_rsp_slot u_ls_slot (
        .clk           (clk),
        .rst           (rst),
        .i_accept      (w_grant_ls),
        .i_err         (w_ls_err),
        .i_keep_data   (~w_ls_req.we),
        .i_mem_data_out(mem_data_out),
        .i_rsp_ready   (ls_rsp_ready),
        .o_eligible    (w_ls_slot_elig),
        .o_rsp_valid   (ls_rsp_valid),
        .o_rsp_data    (ls_rsp_rdata),
        .o_rsp_err     (ls_rsp_err)
    );

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios then random traffic, checked against
// a transaction-level model of grants, memory contents and pending responses.
module tb_mem_arbiter;

    localparam int unsigned DEPTH = 255;

    logic        clk;
    logic        rst;
    logic        if_req_valid;
    logic        if_req_ready;
    logic [31:0] if_req_addr;
    logic        if_rsp_valid;
    logic        if_rsp_ready;
    logic [31:0] if_rsp_data;
    logic        if_rsp_err;
    logic        ls_req_valid;
    logic        ls_req_ready;
    logic        ls_req_we;
    logic [31:0] ls_req_addr;
    logic [31:0] ls_req_wdata;
    logic [3:0]  ls_req_mask;
    logic        ls_rsp_valid;
    logic        ls_rsp_ready;
    logic [31:0] ls_rsp_rdata;
    logic        ls_rsp_err;
    logic        mem_request;
    logic        mem_we_re;
    logic [7:0]  mem_address;
    logic [31:0] mem_data_in;
    logic [3:0]  mem_mask;
    logic [31:0] mem_data_out;

    mem_arbiter #(.MEM_AW(8), .MEM_DEPTH(255), .LS_FIRST(1)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_addr(if_req_addr),
        .if_rsp_valid(if_rsp_valid), .if_rsp_ready(if_rsp_ready), .if_rsp_data(if_rsp_data),
        .if_rsp_err(if_rsp_err),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_we(ls_req_we),
        .ls_req_addr(ls_req_addr), .ls_req_wdata(ls_req_wdata), .ls_req_mask(ls_req_mask),
        .ls_rsp_valid(ls_rsp_valid), .ls_rsp_ready(ls_rsp_ready), .ls_rsp_rdata(ls_rsp_rdata),
        .ls_rsp_err(ls_rsp_err),
        .mem_request(mem_request), .mem_we_re(mem_we_re), .mem_address(mem_address),
        .mem_data_in(mem_data_in), .mem_mask(mem_mask), .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Memory seen by the DUT, and the model's own view of what memory should hold.
    logic [31:0] tb_mem  [256];
    logic [31:0] ref_mem [256];
    logic        p_req, p_we;
    logic [7:0]  p_addr;
    logic [31:0] p_wdata;
    logic [3:0]  p_mask;

    // Model state: outstanding response per port and who wins the next conflict.
    logic        m_if_pend, m_if_err, m_ls_pend, m_ls_err, m_ls_prio;
    logic [31:0] m_if_data, m_ls_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a / 4 >= DEPTH);
    endfunction

    function automatic logic [31:0] rand_addr();
        int unsigned k = $urandom_range(0, 9);
        if (k == 0) return 32'($urandom_range(0, 127) * 4 + $urandom_range(1, 3));
        if (k == 1) return ($urandom_range(0, 1) == 1) ? 32'h3FC : ($urandom | 32'h400);
        if (k == 2) return 32'd254 * 4;
        return 32'($urandom_range(0, 31) * 4);
    endfunction

    // Registered-read memory: applies the request captured in the previous cycle.
    task automatic mem_tick();
        if (p_req) begin
            if (p_we) begin
                for (int b = 0; b < 4; b++)
                    if (p_mask[b]) tb_mem[p_addr][8*b +: 8] = p_wdata[8*b +: 8];
            end else begin
                mem_data_out = tb_mem[p_addr];
            end
        end
    endtask

    task automatic capture();
        p_req   = mem_request;
        p_we    = mem_we_re;
        p_addr  = mem_address;
        p_wdata = mem_data_in;
        p_mask  = mem_mask;
    endtask

    task automatic model_reset();
        m_if_pend = 1'b0; m_ls_pend = 1'b0; m_ls_prio = 1'b1;
        m_if_err  = 1'b0; m_ls_err  = 1'b0;
        m_if_data = 32'd0; m_ls_data = 32'd0;
        p_req = 1'b0; p_we = 1'b0; p_addr = 8'd0; p_wdata = 32'd0; p_mask = 4'd0;
    endtask

    task automatic step(input logic iv, input logic [31:0] ia, input logic irr,
                        input logic lv, input logic lwe, input logic [31:0] la,
                        input logic [31:0] lwd, input logic [3:0] lm, input logic lrr);
        logic e_if, e_ls, g_if, g_ls, bad_if, bad_ls, exp_req;
        @(posedge clk);
        #1;
        mem_tick();
        if_req_valid = iv; if_req_addr = ia; if_rsp_ready = irr;
        ls_req_valid = lv; ls_req_we = lwe; ls_req_addr = la;
        ls_req_wdata = lwd; ls_req_mask = lm; ls_rsp_ready = lrr;
        @(negedge clk);
        bad_if = is_bad(ia);
        bad_ls = is_bad(la);
        e_if = iv && (!m_if_pend || irr);
        e_ls = lv && (!m_ls_pend || lrr);
        g_ls = e_ls && (!e_if || m_ls_prio);
        g_if = e_if && !g_ls;
        exp_req = (g_if && !bad_if) || (g_ls && !bad_ls);
        chk("if_req_ready", if_req_ready, g_if);
        chk("ls_req_ready", ls_req_ready, g_ls);
        chk("if_rsp_valid", if_rsp_valid, m_if_pend);
        chk("ls_rsp_valid", ls_rsp_valid, m_ls_pend);
        if (m_if_pend) begin
            chk("if_rsp_data", if_rsp_data, m_if_data);
            chk("if_rsp_err", if_rsp_err, m_if_err);
        end
        if (m_ls_pend) begin
            chk("ls_rsp_rdata", ls_rsp_rdata, m_ls_data);
            chk("ls_rsp_err", ls_rsp_err, m_ls_err);
        end
        chk("mem_request", mem_request, exp_req);
        if (exp_req) begin
            chk("mem_address", mem_address, g_ls ? la / 4 : ia / 4);
            chk("mem_we_re", mem_we_re, g_ls && lwe);
            if (g_ls && lwe) begin
                chk("mem_data_in", mem_data_in, lwd);
                chk("mem_mask", mem_mask, lm);
            end
        end
        if (m_if_pend && irr) m_if_pend = 1'b0;
        if (m_ls_pend && lrr) m_ls_pend = 1'b0;
        if (e_if && e_ls) m_ls_prio = !g_ls;
        if (g_if) begin
            m_if_pend = 1'b1;
            m_if_err  = bad_if;
            m_if_data = bad_if ? 32'd0 : ref_mem[ia / 4];
        end
        if (g_ls) begin
            m_ls_pend = 1'b1;
            m_ls_err  = bad_ls;
            m_ls_data = (bad_ls || lwe) ? 32'd0 : ref_mem[la / 4];
            if (lwe && !bad_ls)
                for (int b = 0; b < 4; b++)
                    if (lm[b]) ref_mem[la / 4][8*b +: 8] = lwd[8*b +: 8];
        end
        capture();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 1, 0, 0, 0, 0, 0, 1);
    endtask

    initial begin
        logic [31:0] v;
        for (int i = 0; i < 256; i++) begin
            v = $urandom;
            tb_mem[i] = v;
            ref_mem[i] = v;
        end
        tb_mem[4] = 32'hDEADBEEF;
        ref_mem[4] = 32'hDEADBEEF;
        model_reset();
        mem_data_out = 32'd0;
        if_req_valid = 0; if_req_addr = 0; if_rsp_ready = 0;
        ls_req_valid = 0; ls_req_we = 0; ls_req_addr = 0;
        ls_req_wdata = 0; ls_req_mask = 0; ls_rsp_ready = 0;
        rst = 1'b1;
        #3;
        chk("reset if_rsp_valid", if_rsp_valid, 0);
        chk("reset ls_rsp_valid", ls_rsp_valid, 0);
        chk("reset if_rsp_data", if_rsp_data, 0);
        chk("reset ls_rsp_err", ls_rsp_err, 0);
        chk("reset mem_request", mem_request, 0);
        #20 rst = 1'b0;

        // IF fetch of word 4, then the response cycle.
        step(1, 32'h10, 1, 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 1);
        chk("if fetch deadbeef", if_rsp_data, 32'hDEADBEEF);

        // Partial store then back-to-back load of the same word.
        step(0, 0, 1, 1, 1, 32'h20, 32'h11223344, 4'b0011, 1);
        step(0, 0, 1, 1, 0, 32'h20, 0, 0, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 1);

        // Contention from both ports: LS, IF, LS, IF.
        for (int i = 0; i < 4; i++) begin
            step(1, 32'(4 * (8 + i)), 1, 1, 0, 32'(4 * (16 + i)), 0, 0, 1);
            chk("alternating grant", ls_req_ready, (i % 2 == 0) ? 1 : 0);
        end
        idle(1);

        // IF stalled on its response while LS streams reads.
        step(1, 32'h10, 0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++)
            step(1, 32'h14, 0, 1, 0, 32'(4 * (40 + i)), 0, 0, 1);
        chk("if held data", if_rsp_data, 32'hDEADBEEF);
        step(1, 32'h14, 1, 0, 0, 0, 0, 0, 1);
        idle(2);

        // Misaligned LS and out-of-range IF, presented together.
        step(1, 32'h3FC, 1, 1, 0, 32'h22, 0, 0, 1);
        step(1, 32'h3FC, 1, 1, 1, 32'h22, 32'hFFFFFFFF, 4'hF, 1);
        step(0, 0, 1, 0, 0, 0, 0, 0, 1);
        idle(1);

        for (int i = 0; i < 500; i++)
            step($urandom_range(0, 3) != 0, rand_addr(), $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, rand_addr(),
                 $urandom, 4'($urandom), $urandom_range(0, 2) != 0);
        idle(3);

        // Asynchronous reset while an IF read is pending.
        step(1, 32'h10, 0, 0, 0, 0, 0, 0, 1);
        @(posedge clk);
        #1;
        mem_tick();
        if_req_valid = 0; ls_req_valid = 0;
        #2;
        chk("pend before reset", if_rsp_valid, 1);
        rst = 1'b1;
        #1;
        chk("valid drops in reset", if_rsp_valid, 0);
        #2 rst = 1'b0;
        model_reset();
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
